// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin arbiter sharing one registered-output ALU between
// two requesters, with valid/ready request and response handshakes.
// Only one operation is in flight at a time.
// Optional performance counters are built when ALU_ARB_PERF_EN is defined.
// Otherwise o_cnt_ops and o_cnt_err are tied to zero.

module alu_arbiter #(
    parameter int unsigned N       = 4,
    parameter int unsigned M       = 8,
    parameter int unsigned K       = 8,
    parameter int unsigned ALU_LAT = 1
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic [1:0]       i_req_valid,
    input  logic [2*N-1:0]   i_req_op,
    input  logic [2*M-1:0]   i_req_arg_A,
    input  logic [2*M-1:0]   i_req_arg_B,
    output logic [1:0]       o_req_ready,
    output logic [1:0]       o_rsp_valid,
    input  logic [1:0]       i_rsp_ready,
    output logic [K-1:0]     o_rsp_result,
    output logic [3:0]       o_rsp_status,
    output logic             o_rsp_error,
    output logic [N-1:0]     o_alu_op,
    output logic [M-1:0]     o_alu_arg_A,
    output logic [M-1:0]     o_alu_arg_B,
    input  logic [K-1:0]     i_alu_result,
    input  logic [3:0]       i_alu_status,
    input  logic             i_alu_error,
    output logic [31:0]      o_cnt_ops,
    output logic [15:0]      o_cnt_err
);

    localparam int unsigned CW = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t          state;
    logic            rr_ptr;
    logic            owner;
    logic [CW-1:0]   wait_cnt;

    logic            accept;
    logic            grant_id;
    logic            rsp_hs;
    logic [N-1:0]    sel_op;
    logic [M-1:0]    sel_a;
    logic [M-1:0]    sel_b;

    // Grant: one-hot to the winner while idle; pointer only breaks ties.
    always_comb begin
        o_req_ready = 2'b00;
        if (state == S_IDLE) begin
            case (i_req_valid)
                2'b01:   o_req_ready = 2'b01;
                2'b10:   o_req_ready = 2'b10;
                2'b11:   o_req_ready = rr_ptr ? 2'b10 : 2'b01;
                default: o_req_ready = 2'b00;
            endcase
        end
    end

    assign accept   = |(i_req_valid & o_req_ready);
    assign grant_id = o_req_ready[1];
    assign rsp_hs   = (state == S_RESP) && i_rsp_ready[owner];
    assign sel_op   = grant_id ? i_req_op[N +: N]    : i_req_op[0 +: N];
    assign sel_a    = grant_id ? i_req_arg_A[M +: M] : i_req_arg_A[0 +: M];
    assign sel_b    = grant_id ? i_req_arg_B[M +: M] : i_req_arg_B[0 +: M];

    // Operation sequencer; the ALU drive registers double as the operand latch.
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            state        <= S_IDLE;
            rr_ptr       <= 1'b0;
            owner        <= 1'b0;
            wait_cnt     <= '0;
            o_rsp_valid  <= 2'b00;
            o_rsp_result <= '0;
            o_rsp_status <= 4'd0;
            o_rsp_error  <= 1'b0;
            o_alu_op     <= '0;
            o_alu_arg_A  <= '0;
            o_alu_arg_B  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        owner       <= grant_id;
                        rr_ptr      <= ~grant_id;
                        o_alu_op    <= sel_op;
                        o_alu_arg_A <= sel_a;
                        o_alu_arg_B <= sel_b;
                        state       <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    wait_cnt <= CW'(ALU_LAT - 1);
                    state    <= S_WAIT;
                end
                S_WAIT: begin
                    if (wait_cnt == '0) begin
                        o_rsp_result <= i_alu_result;
                        o_rsp_status <= i_alu_status;
                        o_rsp_error  <= i_alu_error;
                        o_rsp_valid  <= {owner, ~owner};
                        o_alu_op     <= '0;
                        o_alu_arg_A  <= '0;
                        o_alu_arg_B  <= '0;
                        state        <= S_RESP;
                    end else begin
                        wait_cnt <= wait_cnt - CW'(1);
                    end
                end
                S_RESP: begin
                    if (rsp_hs) begin
                        o_rsp_valid <= 2'b00;
                        state       <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef ALU_ARB_PERF_EN
    logic [15:0] cnt_ops0;
    logic [15:0] cnt_ops1;
    logic [15:0] cnt_err;

    // Saturating per-requester completion and error counters.
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            cnt_ops0 <= 16'd0;
            cnt_ops1 <= 16'd0;
            cnt_err  <= 16'd0;
        end else if (rsp_hs) begin
            if (!owner && cnt_ops0 != 16'hFFFF) cnt_ops0 <= cnt_ops0 + 16'd1;
            if (owner && cnt_ops1 != 16'hFFFF)  cnt_ops1 <= cnt_ops1 + 16'd1;
            if (o_rsp_error && cnt_err != 16'hFFFF) cnt_err <= cnt_err + 16'd1;
        end
    end

    assign o_cnt_ops = {cnt_ops1, cnt_ops0};
    assign o_cnt_err = cnt_err;
`else
    assign o_cnt_ops = 32'd0;
    assign o_cnt_err = 16'd0;
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: one instance with ALU_LAT=1 and one with
// ALU_LAT=3, each fed by a combinational ALU stand-in.

module tb_alu_arbiter;

    logic        clk = 1'b0;
    logic        reset_n;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // ALU stand-in: 1 add, 2 sub, otherwise xor.
    function automatic logic [7:0] alu_model(input logic [3:0] op, input logic [7:0] a,
                                             input logic [7:0] b);
        case (op)
            4'd1:    return a + b;
            4'd2:    return a - b;
            default: return a ^ b;
        endcase
    endfunction

    // Instance with ALU_LAT = 1
    logic [1:0]  req_valid, req_ready, rsp_valid, rsp_ready;
    logic [7:0]  req_op;
    logic [15:0] req_a, req_b;
    logic [7:0]  rsp_result;
    logic [3:0]  rsp_status;
    logic        rsp_error;
    logic [3:0]  alu_op;
    logic [7:0]  alu_a, alu_b, alu_res;
    logic        force_err;
    logic [31:0] cnt_ops;
    logic [15:0] cnt_err;

    assign alu_res = alu_model(alu_op, alu_a, alu_b);

    alu_arbiter #(.N(4), .M(8), .K(8), .ALU_LAT(1)) dut (
        .i_clk(clk), .i_reset(reset_n),
        .i_req_valid(req_valid), .i_req_op(req_op),
        .i_req_arg_A(req_a), .i_req_arg_B(req_b),
        .o_req_ready(req_ready), .o_rsp_valid(rsp_valid), .i_rsp_ready(rsp_ready),
        .o_rsp_result(rsp_result), .o_rsp_status(rsp_status), .o_rsp_error(rsp_error),
        .o_alu_op(alu_op), .o_alu_arg_A(alu_a), .o_alu_arg_B(alu_b),
        .i_alu_result(alu_res), .i_alu_status({3'b000, force_err}), .i_alu_error(force_err),
        .o_cnt_ops(cnt_ops), .o_cnt_err(cnt_err)
    );

    // Instance with ALU_LAT = 3
    logic [1:0]  l_req_valid, l_req_ready, l_rsp_valid, l_rsp_ready;
    logic [7:0]  l_req_op;
    logic [15:0] l_req_a, l_req_b;
    logic [7:0]  l_rsp_result;
    logic [3:0]  l_rsp_status;
    logic        l_rsp_error;
    logic [3:0]  l_alu_op;
    logic [7:0]  l_alu_a, l_alu_b, l_alu_res;
    logic [31:0] l_cnt_ops;
    logic [15:0] l_cnt_err;

    assign l_alu_res = alu_model(l_alu_op, l_alu_a, l_alu_b);

    alu_arbiter #(.N(4), .M(8), .K(8), .ALU_LAT(3)) dut_l3 (
        .i_clk(clk), .i_reset(reset_n),
        .i_req_valid(l_req_valid), .i_req_op(l_req_op),
        .i_req_arg_A(l_req_a), .i_req_arg_B(l_req_b),
        .o_req_ready(l_req_ready), .o_rsp_valid(l_rsp_valid), .i_rsp_ready(l_rsp_ready),
        .o_rsp_result(l_rsp_result), .o_rsp_status(l_rsp_status), .o_rsp_error(l_rsp_error),
        .o_alu_op(l_alu_op), .o_alu_arg_A(l_alu_a), .o_alu_arg_B(l_alu_b),
        .i_alu_result(l_alu_res), .i_alu_status(4'd0), .i_alu_error(1'b0),
        .o_cnt_ops(l_cnt_ops), .o_cnt_err(l_cnt_err)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    initial begin
        logic [31:0] exp_ops;
        logic [15:0] exp_err;
        logic [1:0]  g;
        int          n;

`ifdef ALU_ARB_PERF_EN
        exp_ops = {16'd3, 16'd5};
        exp_err = 16'd1;
`else
        exp_ops = 32'd0;
        exp_err = 16'd0;
`endif
        reset_n   = 1'b0;
        req_valid = 2'b00; req_op = 8'd0; req_a = 16'd0; req_b = 16'd0;
        rsp_ready = 2'b00; force_err = 1'b0;
        l_req_valid = 2'b00; l_req_op = 8'd0; l_req_a = 16'd0; l_req_b = 16'd0;
        l_rsp_ready = 2'b00;
        tick(); tick();

        // Reset state
        check("rst_req_ready", 32'(req_ready), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_alu_op",    32'(alu_op),    32'd0);
        check("rst_result",    32'(rsp_result), 32'd0);
        check("rst_cnt_ops",   cnt_ops,        32'd0);

        // Single op from requester 0: 3 + 4
        reset_n   = 1'b1;
        req_valid = 2'b01; req_op = {4'd0, 4'd1};
        req_a = {8'h00, 8'h03}; req_b = {8'h00, 8'h04}; rsp_ready = 2'b01;
        #1;
        check("single_ready", 32'(req_ready), 32'd1);
        tick();                                      // accept -> ISSUE
        check("issue_ready0", 32'(req_ready), 32'd0);
        check("issue_alu_op", 32'(alu_op), 32'd1);
        check("issue_alu_a",  32'(alu_a),  32'h03);
        check("issue_alu_b",  32'(alu_b),  32'h04);
        req_valid = 2'b00;
        tick();                                      // WAIT
        check("wait_alu_a",     32'(alu_a),     32'h03);
        check("wait_rsp_valid", 32'(rsp_valid), 32'd0);
        tick();                                      // RESP, accept+3
        check("single_rsp_valid", 32'(rsp_valid),  32'b01);
        check("single_result",    32'(rsp_result), 32'h07);
        check("resp_alu_op0",     32'(alu_op),     32'd0);
        tick();                                      // handshake -> IDLE
        check("single_done", 32'(rsp_valid), 32'd0);

        // Contention: pointer now 1, grants must alternate 1,0,1,0
        req_valid = 2'b11; req_op = {4'd2, 4'd1};
        req_a = {8'd10, 8'd10}; req_b = {8'd5, 8'd5}; rsp_ready = 2'b11;
        #1;
        for (int i = 0; i < 4; i++) begin
            g = (i % 2 == 0) ? 2'b10 : 2'b01;
            n = 0;
            while (req_ready == 2'b00 && n < 10) begin
                tick();
                n++;
            end
            check($sformatf("cont_grant%0d", i), 32'(req_ready), 32'(g));
            tick(); tick(); tick();
            check($sformatf("cont_valid%0d", i), 32'(rsp_valid), 32'(g));
            check($sformatf("cont_result%0d", i), 32'(rsp_result),
                  (g == 2'b10) ? 32'd5 : 32'd15);
            if (i == 3) req_valid = 2'b00;
            tick();
        end

        // Backpressure on requester 0 while requester 1 waits
        req_valid = 2'b01; req_op = {4'd2, 4'd1};
        req_a = {8'd10, 8'd1}; req_b = {8'd5, 8'd2}; rsp_ready = 2'b00;
        #1;
        check("bp_ready", 32'(req_ready), 32'b01);
        tick();
        req_valid = 2'b00;
        tick(); tick();
        check("bp_rsp_valid", 32'(rsp_valid),  32'b01);
        check("bp_result",    32'(rsp_result), 32'd3);
        req_valid = 2'b10; rsp_ready = 2'b10;        // non-owner ready ignored
        for (int i = 0; i < 5; i++) begin
            tick();
            check($sformatf("bp_hold_valid%0d", i),  32'(rsp_valid),  32'b01);
            check($sformatf("bp_hold_result%0d", i), 32'(rsp_result), 32'd3);
            check($sformatf("bp_hold_ready%0d", i),  32'(req_ready),  32'd0);
        end
        rsp_ready = 2'b01;
        tick();
        check("bp_release_valid", 32'(rsp_valid), 32'd0);
        check("bp_req1_ready",    32'(req_ready), 32'b10);
        tick();
        req_valid = 2'b00; rsp_ready = 2'b10;
        tick(); tick();
        check("bp_req1_valid",  32'(rsp_valid),  32'b10);
        check("bp_req1_result", 32'(rsp_result), 32'd5);
        tick();

        // Error path: status[0]=1 and error=1, response still delivered
        force_err = 1'b1;
        req_valid = 2'b01; req_op = {4'd0, 4'd3};
        req_a = {8'h00, 8'hF0}; req_b = {8'h00, 8'h0F}; rsp_ready = 2'b01;
        #1;
        check("err_ready", 32'(req_ready), 32'b01);
        tick();
        req_valid = 2'b00;
        tick(); tick();
        check("err_rsp_valid", 32'(rsp_valid),  32'b01);
        check("err_flag",      32'(rsp_error),  32'd1);
        check("err_status",    32'(rsp_status), 32'd1);
        check("err_result",    32'(rsp_result), 32'hFF);
        tick();
        force_err = 1'b0;
        check("err_done",    32'(rsp_valid), 32'd0);
        check("cnt_ops",     cnt_ops,        exp_ops);
        check("cnt_err",     32'(cnt_err),   32'(exp_err));

        // Reset during WAIT drops the op
        req_valid = 2'b01; req_op = {4'd0, 4'd1};
        req_a = {8'h00, 8'h03}; req_b = {8'h00, 8'h04}; rsp_ready = 2'b01;
        tick();
        req_valid = 2'b00;
        tick();                                      // WAIT
        reset_n = 1'b0;
        tick();
        check("mid_rst_valid",  32'(rsp_valid),  32'd0);
        check("mid_rst_alu_op", 32'(alu_op),     32'd0);
        check("mid_rst_alu_a",  32'(alu_a),      32'd0);
        check("mid_rst_result", 32'(rsp_result), 32'd0);
        check("mid_rst_error",  32'(rsp_error),  32'd0);
        check("mid_rst_cnt",    cnt_ops,         32'd0);
        reset_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("mid_rst_quiet%0d", i), 32'(rsp_valid), 32'd0);
        end
        req_valid = 2'b11;
        #1;
        check("mid_rst_ptr0", 32'(req_ready), 32'b01);
        req_valid = 2'b00;

        // ALU_LAT = 3: response at accept+5, ALU drive stable through WAIT
        l_req_valid = 2'b01; l_req_op = {4'd0, 4'd1};
        l_req_a = {8'd0, 8'd20}; l_req_b = {8'd0, 8'd22}; l_rsp_ready = 2'b00;
        #1;
        check("l3_ready", 32'(l_req_ready), 32'b01);
        tick();
        l_req_valid = 2'b00;
        for (int i = 1; i < 5; i++) begin
            check($sformatf("l3_valid_low%0d", i), 32'(l_rsp_valid), 32'd0);
            check($sformatf("l3_alu_op%0d", i),    32'(l_alu_op),    32'd1);
            check($sformatf("l3_alu_a%0d", i),     32'(l_alu_a),     32'd20);
            tick();
        end
        check("l3_rsp_valid", 32'(l_rsp_valid),  32'b01);
        check("l3_result",    32'(l_rsp_result), 32'd42);
        l_rsp_ready = 2'b01;
        tick();
        check("l3_done", 32'(l_rsp_valid), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
